video_stream_gen: RTL
=====================

// Module: video_stream_gen
// PURPOSE
//   Transmit side of the ycbcr_vs/hs/de/y pixel stream consumed by the 3x3 window builder.
//   Reads an 8-bit luma image from a synchronous RAM and emits it with programmable raster
//   timing, one pixel per clock. It is the frame source for recognition benches and replay.
// PARAMETERS
//   H_ACTIVE    640  active pixels per line
//   H_FP        16   line front porch, clocks
//   H_SYNC      96   line sync pulse, clocks
//   H_BP        48   line back porch, clocks
//   V_ACTIVE    480  active lines per frame
//   V_FP        10   frame front porch, lines
//   V_SYNC      2    frame sync pulse, lines
//   V_BP        33   frame back porch, lines
//   ADDR_W      19   RAM address width; 2**ADDR_W >= H_ACTIVE*V_ACTIVE
//   CONTINUOUS  0    1: restart a new frame automatically after each frame
// PORTS
//   clk         in   1       single clock, all logic on rising edge
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       one-cycle request to send a frame; honoured only in IDLE
//   busy        out  1       high from the cycle after start is accepted until frame_done
//   frame_done  out  1       one-cycle pulse after the last pipelined output of a frame
//   mem_rd      out  1       RAM read enable
//   mem_addr    out  ADDR_W  RAM read address, raster order
//   mem_data    in   8       RAM read data, valid exactly 1 clk after mem_rd
//   ycbcr_vs    out  1       frame sync, low during V_SYNC lines, high otherwise
//   ycbcr_hs    out  1       line sync, low during H_SYNC clocks, high otherwise
//   ycbcr_de    out  1       pixel valid, high only in active pixels of active lines
//   ycbcr_y     out  8       pixel luma; 0 when ycbcr_de is low
// BEHAVIOUR
//   Reset (asynchronous): FSM=IDLE, counters=0, busy=0, frame_done=0, mem_rd=0, mem_addr=0,
//   vs=1, hs=1, de=0, y=0. Pipeline registers are cleared. Reset mid-frame aborts the frame
//   and does not pulse frame_done.
//   FSM states:
//   - IDLE: start=1 -> RUN; hcnt=0, vcnt=0 in the next cycle.
//   - RUN: hcnt runs 0..H_TOTAL-1, then wraps and vcnt increments.
//     On hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1 -> FLUSH.
//   - FLUSH: 3 cycles, then frame_done=1 for 1 cycle.
//     After that: -> IDLE, or -> RUN when CONTINUOUS=1.
//   In CONTINUOUS mode, the next frame's (0,0) follows the flush. start is ignored in RUN and FLUSH.
//   H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; region order: active, FP, sync, BP.
//   V_TOTAL follows the same rule and the same region order.
//   Stage 0 (cycle n, counter at (h,v)): decode de0, hs0, vs0.
//   Stage 1 (cycle n+1): mem_rd=de0 and mem_addr registered; flags delayed.
//   Stage 2 (cycle n+2): mem_data valid; flags delayed.
//   Stage 3 (cycle n+3): ycbcr_* registered. y=mem_data if de else 0.
//   Fixed latency is 3 clk from counter to ports; all four outputs stay mutually aligned.
//   Address counter increments after each mem_rd. It is cleared to 0 at (0,0) of every frame.
//   It is never compared with 2**ADDR_W, because the maximum is H_ACTIVE*V_ACTIVE-1.
//   busy clears in the same cycle as frame_done (IDLE); in CONTINUOUS mode busy stays high.
//   A start that coincides with frame_done is ignored; it must be raised again in IDLE.
// STRUCTURE
//   Shared include video_timing_defs.vh holds:
//   - FSM state encodings (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2);
//   - the default 640x480 timing constants;
//   - the PIPE_LAT=3 constant, shared with the matrix/filter benches.
//   Sub-module video_timing_cnt: hcnt/vcnt, region decode, end-of-frame flag.
//   Top level: FSM, address counter, 3-stage alignment pipeline.
// TESTING
//   Use small timing: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), 48 clk/frame.
//   The RAM model returns mem[a]=8'h10+a.
//   1. Hold rst=1 -> outputs are 1,1,0,0, busy=0, mem_rd=0. Assert rst while clk is stopped
//      -> outputs take reset values immediately.
//   2. Pulse start at edge k -> first de=1 at cycle k+4 with y=8'h10.
//      Expect 12 de cycles in 3 runs of 4, with y=8'h10..8'h1B in order and y=0 elsewhere.
//   3. Check the same frame -> hs low for exactly 2 clk per line (6 lines). vs low for exactly
//      8 clk starting at line 4. de is never high while hs or vs is low.
//   4. frame_done pulses once, 48+3 clk after counter start; busy falls with it.
//      A start pulsed during RUN -> no second frame.
//   5. CONTINUOUS=1 -> frames repeat every 51 clk. Every frame restarts at mem_addr=0 and y=8'h10.
//   6. Assert rst in the middle of an active line (3rd pixel of line 1) -> same-cycle idle
//      outputs and no frame_done. The next start replays from address 0.
//   Feed the output stream into the 3x3 window builder -> p22 at center (1,1) equals 8'h15.

Source files
------------

// File: rtl/video_stream_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_stream_gen_pkg
// Brief   : FSM encoding, default 640x480 raster timing and pipeline latency
//           shared by the video stream generator and its neighbours.
// Rev     : 1.0  initial release
// ============================================================================
package video_stream_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int c_DEF_H_ACTIVE = 640;
    localparam int c_DEF_H_FP     = 16;
    localparam int c_DEF_H_SYNC   = 96;
    localparam int c_DEF_H_BP     = 48;
    localparam int c_DEF_V_ACTIVE = 480;
    localparam int c_DEF_V_FP     = 10;
    localparam int c_DEF_V_SYNC   = 2;
    localparam int c_DEF_V_BP     = 33;
    localparam int c_DEF_ADDR_W   = 19;

    // Counter-to-port latency; the matrix/filter benches align against this.
    localparam int c_PIPE_LAT = 3;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : video_stream_gen_if
// Brief   : RAM read port and ycbcr pixel stream of the video stream generator.
// Rev     : 1.0  initial release
// ============================================================================
interface video_stream_gen_if #(
    parameter int ADDR_W = 19
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              ycbcr_vs;
    logic              ycbcr_hs;
    logic              ycbcr_de;
    logic [7:0]        ycbcr_y;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        output ycbcr_vs, ycbcr_hs, ycbcr_de, ycbcr_y
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        input  ycbcr_vs, ycbcr_hs, ycbcr_de, ycbcr_y
    );
endinterface
`default_nettype wire

// File: rtl/video_stream_gen_timing_cnt.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_cnt
// Brief   : Raster h/v counters with region decode and start/end-of-frame flags.
// Rev     : 1.0  initial release
// ============================================================================
module video_timing_cnt
    import video_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE = c_DEF_H_ACTIVE,
    parameter int H_FP     = c_DEF_H_FP,
    parameter int H_SYNC   = c_DEF_H_SYNC,
    parameter int H_BP     = c_DEF_H_BP,
    parameter int V_ACTIVE = c_DEF_V_ACTIVE,
    parameter int V_FP     = c_DEF_V_FP,
    parameter int V_SYNC   = c_DEF_V_SYNC,
    parameter int V_BP     = c_DEF_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_de0,
    output logic o_hs0,
    output logic o_vs0,
    output logic o_sof,
    output logic o_eof
);
    localparam int c_H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    // One spare bit so sync-end bounds equal to the total still fit.
    localparam int c_HW = $clog2(c_H_TOTAL + 1);
    localparam int c_VW = $clog2(c_V_TOTAL + 1);

    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic            w_h_last;
    logic            w_v_last;

    assign w_h_last = (r_hcnt == c_H_LAST);
    assign w_v_last = (r_vcnt == c_V_LAST);

    // Counters rest at (0,0) outside RUN; the end-of-frame wrap leaves them there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_en) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign o_de0 = i_en && (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign o_hs0 = !(i_en && (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END));
    assign o_vs0 = !(i_en && (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END));
    assign o_sof = i_en && (r_hcnt == '0) && (r_vcnt == '0);
    assign o_eof = i_en && w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: rtl/video_stream_gen.sv
`default_nettype none
// ============================================================================
// Module  : video_stream_gen
// Brief   : Reads an 8-bit luma frame from sync RAM and emits it as a
//           vs/hs/de/y raster stream, one pixel per clock.
// Rev     : 1.0  initial release
// ============================================================================
module video_stream_gen
    import video_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE   = c_DEF_H_ACTIVE,
    parameter int H_FP       = c_DEF_H_FP,
    parameter int H_SYNC     = c_DEF_H_SYNC,
    parameter int H_BP       = c_DEF_H_BP,
    parameter int V_ACTIVE   = c_DEF_V_ACTIVE,
    parameter int V_FP       = c_DEF_V_FP,
    parameter int V_SYNC     = c_DEF_V_SYNC,
    parameter int V_BP       = c_DEF_V_BP,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    video_stream_gen_if.master vid
);
    localparam logic [1:0] c_FLUSH_LAST = 2'(c_PIPE_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_flush_cnt;
    logic              r_frame_done;

    logic              w_de0, w_hs0, w_vs0, w_sof, w_eof;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [ADDR_W-1:0] w_addr_base;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_rd1, r_hs1, r_vs1;
    logic              r_de2, r_hs2, r_vs2;
    logic              r_out_de, r_out_hs, r_out_vs;
    logic [7:0]        r_out_y;

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_state == ST_RUN),
        .o_de0 (w_de0),
        .o_hs0 (w_hs0),
        .o_vs0 (w_vs0),
        .o_sof (w_sof),
        .o_eof (w_eof)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start landing on the frame_done cycle is dropped on purpose.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start && !r_frame_done) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_eof) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == c_FLUSH_LAST)
                          w_state_nxt = CONTINUOUS ? ST_RUN : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt  <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_flush_cnt  <= (r_state == ST_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
            r_frame_done <= (r_state == ST_FLUSH) && (r_flush_cnt == c_FLUSH_LAST);
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

    // The read address restarts at 0 on every frame's first pixel.
    assign w_addr_base = w_sof ? '0 : r_addr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_cnt <= '0;
            r_mem_addr <= '0;
        end else if (w_de0) begin
            r_mem_addr <= w_addr_base;
            r_addr_cnt <= w_addr_base + 1'b1;
        end else if (w_sof) begin
            r_addr_cnt <= '0;
        end
    end

    // Sync/valid flags ride alongside the RAM read so all ports stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1    <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_de2    <= 1'b0;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_out_de <= 1'b0;
            r_out_hs <= 1'b1;
            r_out_vs <= 1'b1;
            r_out_y  <= 8'h00;
        end else begin
            r_rd1    <= w_de0;
            r_hs1    <= w_hs0;
            r_vs1    <= w_vs0;
            r_de2    <= r_rd1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_out_de <= r_de2;
            r_out_hs <= r_hs2;
            r_out_vs <= r_vs2;
            r_out_y  <= r_de2 ? vid.mem_data : 8'h00;
        end
    end

    assign vid.mem_rd   = r_rd1;
    assign vid.mem_addr = r_mem_addr;
    assign vid.ycbcr_de = r_out_de;
    assign vid.ycbcr_hs = r_out_hs;
    assign vid.ycbcr_vs = r_out_vs;
    assign vid.ycbcr_y  = r_out_y;

endmodule
`default_nettype wire
